fla_cmd_seq: RTL and testbench



---
 rtl/fla_pkg.sv | 36 +++
 rtl/fla_mem_if.sv | 45 ++++
 rtl/fla_cmd_seq.sv | 218 +++++++++++++++++++++
 tb/tb_fla_cmd_seq.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fla_pkg.sv
// Shared constants for the flash command sequencer: state encoding,
// JEDEC unlock addresses and command bytes.
package fla_pkg;

    typedef logic [3:0] fla_state_t;

    localparam fla_state_t ST_IDLE   = 4'd0;
    localparam fla_state_t ST_UNL1   = 4'd1;
    localparam fla_state_t ST_UNL2   = 4'd2;
    localparam fla_state_t ST_ARM    = 4'd3;
    localparam fla_state_t ST_E80    = 4'd4;
    localparam fla_state_t ST_EUNL1  = 4'd5;
    localparam fla_state_t ST_EUNL2  = 4'd6;
    localparam fla_state_t ST_ID     = 4'd7;
    localparam fla_state_t ST_PRG_RD = 4'd8;
    localparam fla_state_t ST_PRG_WR = 4'd9;
    localparam fla_state_t ST_ERS    = 4'd10;

    localparam logic [14:0] U1 = 15'h5555;
    localparam logic [14:0] U2 = 15'h2AAA;

    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_55 = 8'h55;
    localparam logic [7:0] CMD_A0 = 8'hA0;
    localparam logic [7:0] CMD_80 = 8'h80;
    localparam logic [7:0] CMD_90 = 8'h90;
    localparam logic [7:0] CMD_F0 = 8'hF0;
    localparam logic [7:0] CMD_30 = 8'h30;
    localparam logic [7:0] CMD_10 = 8'h10;

    // States in which the backing memory is being modified.
    function automatic logic is_busy_state(input fla_state_t st);
        return (st == ST_PRG_RD) || (st == ST_PRG_WR) || (st == ST_ERS);
    endfunction

endpackage

// File: rtl/fla_mem_if.sv
// Single-outstanding memory request holder. A start pulse is accepted only
// while no request is pending; address/data are frozen for the whole request
// and mem_req drops in the cycle after mem_ack, which guarantees at least
// one idle cycle between consecutive requests.
module fla_mem_if
    import fla_pkg::*;
#(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              map_rst,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_wdat,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdat,
    output logic              done
);

    assign done = mem_req & mem_ack;

    // Launch a request on start, hold it until acknowledged.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wdat <= '0;
        end else if (mem_req) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end else if (start) begin
            mem_req  <= 1'b1;
            mem_we   <= start_we;
            mem_addr <= start_addr;
            mem_wdat <= start_wdat;
        end
    end

endmodule

// File: rtl/fla_cmd_seq.sv
// SST39SF0x0-style flash command sequencer on top of PSRAM-backed PRG.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | read-array mode, waiting for AA@5555
// UNL1      | AA seen, waiting for 55@2AAA
// UNL2      | unlocked, waiting for command byte @5555
// ARM       | program armed, next write is the target byte
// E80       | erase setup, waiting for AA@5555
// EUNL1     | erase AA seen, waiting for 55@2AAA
// EUNL2     | waiting for 30 (sector) or 10@5555 (chip)
// ID        | software ID mode, reads return MFR/DEV id
// PRG_RD    | reading the current byte at the program address
// PRG_WR    | writing old & new back (flash only clears bits)
// ERS       | filling the erase range with FF
module fla_cmd_seq
    import fla_pkg::*;
#(
    parameter int         ADDR_W      = 19,
    parameter int         SECT_W      = 12,
    parameter logic [7:0] MFR_ID      = 8'hBF,
    parameter logic [7:0] DEV_ID      = 8'hB7,
    parameter bit         CHIP_ERS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              map_rst,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdat,
    input  logic [7:0]        mem_rdat,
    input  logic              mem_ack,
    output logic              rd_ovr,
    output logic [7:0]        rd_ovr_dat,
    output logic              busy,
    output logic              map_led
);

    localparam logic [ADDR_W:0] SECT_CNT = (ADDR_W+1)'(1) << SECT_W;
    localparam logic [ADDR_W:0] CHIP_CNT = (ADDR_W+1)'(1) << ADDR_W;

    fla_state_t        state;
    logic [ADDR_W-1:0] prg_addr;
    logic [7:0]        prg_dat;
    logic [7:0]        rd_dat;
    logic [ADDR_W-1:0] ers_base;
    // One bit wider than the address so a full-chip count is representable.
    logic [ADDR_W:0]   ers_n;
    logic [ADDR_W:0]   ers_cnt;
    logic [ADDR_W:0]   ers_n_nxt;
    logic              ers_last;
    logic              tog;

    logic              is_u1;
    logic              is_u2;
    logic              busy_st;
    logic              mem_start;
    logic              start_we;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        start_wdat;
    logic              mem_done;

    assign is_u1     = (cpu_addr[14:0] == U1);
    assign is_u2     = (cpu_addr[14:0] == U2);
    assign busy_st   = is_busy_state(state);
    assign busy      = busy_st;
    assign map_led   = (state != ST_IDLE);
    assign rd_ovr    = busy_st || (state == ST_ID);
    assign ers_n_nxt = ers_n + (ADDR_W+1)'(1);
    assign ers_last  = (ers_n_nxt == ers_cnt);

    // Status byte while busy (DQ7 = inverted target MSB, DQ6 = toggle), ID bytes in ID mode.
    always_comb begin
        rd_ovr_dat = 8'h00;
        if (busy_st) begin
            rd_ovr_dat = {((state == ST_ERS) ? 1'b0 : ~prg_dat[7]), tog, 6'b0};
        end else if (state == ST_ID) begin
            rd_ovr_dat = cpu_addr[0] ? DEV_ID : MFR_ID;
        end
    end

    // Issue the next memory request whenever a busy state has none pending.
    always_comb begin
        mem_start  = 1'b0;
        start_we   = 1'b0;
        start_addr = prg_addr;
        start_wdat = 8'h00;
        case (state)
            ST_PRG_RD: begin
                mem_start = !mem_req;
            end
            ST_PRG_WR: begin
                mem_start  = !mem_req;
                start_we   = 1'b1;
                start_wdat = rd_dat & prg_dat;
            end
            ST_ERS: begin
                mem_start  = !mem_req;
                start_we   = 1'b1;
                start_addr = ers_base + ers_n[ADDR_W-1:0];
                start_wdat = 8'hFF;
            end
            default: ;
        endcase
    end

    fla_mem_if #(
        .ADDR_W (ADDR_W)
    ) u_mem_if (
        .clk        (clk),
        .map_rst    (map_rst),
        .start      (mem_start),
        .start_we   (start_we),
        .start_addr (start_addr),
        .start_wdat (start_wdat),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdat   (mem_wdat),
        .done       (mem_done)
    );

    // Command decoder and program/erase sequencing.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state    <= ST_IDLE;
            prg_addr <= '0;
            prg_dat  <= '0;
            rd_dat   <= '0;
            ers_base <= '0;
            ers_n    <= '0;
            ers_cnt  <= '0;
            tog      <= 1'b0;
        end else begin
            // A simultaneous write takes priority, so that read does not toggle.
            if (!busy_st) begin
                tog <= 1'b0;
            end else if (cpu_re && !cpu_we) begin
                tog <= ~tog;
            end

            case (state)
                ST_IDLE: begin
                    if (cpu_we && cpu_dat == CMD_AA && is_u1) state <= ST_UNL1;
                end
                ST_UNL1: begin
                    if (cpu_we) state <= (cpu_dat == CMD_55 && is_u2) ? ST_UNL2 : ST_IDLE;
                end
                ST_UNL2: begin
                    if (cpu_we) begin
                        state <= ST_IDLE;
                        if (is_u1) begin
                            case (cpu_dat)
                                CMD_A0:  state <= ST_ARM;
                                CMD_80:  state <= ST_E80;
                                CMD_90:  state <= ST_ID;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ARM: begin
                    if (cpu_we) begin
                        prg_addr <= cpu_addr;
                        prg_dat  <= cpu_dat;
                        state    <= ST_PRG_RD;
                    end
                end
                ST_E80: begin
                    if (cpu_we) state <= (cpu_dat == CMD_AA && is_u1) ? ST_EUNL1 : ST_IDLE;
                end
                ST_EUNL1: begin
                    if (cpu_we) state <= (cpu_dat == CMD_55 && is_u2) ? ST_EUNL2 : ST_IDLE;
                end
                ST_EUNL2: begin
                    if (cpu_we) begin
                        state <= ST_IDLE;
                        ers_n <= '0;
                        if (cpu_dat == CMD_30) begin
                            ers_base <= {cpu_addr[ADDR_W-1:SECT_W], {SECT_W{1'b0}}};
                            ers_cnt  <= SECT_CNT;
                            state    <= ST_ERS;
                        end else if (CHIP_ERS_EN && cpu_dat == CMD_10 && is_u1) begin
                            ers_base <= '0;
                            ers_cnt  <= CHIP_CNT;
                            state    <= ST_ERS;
                        end
                    end
                end
                ST_ID: begin
                    if (cpu_we && cpu_dat == CMD_F0) state <= ST_IDLE;
                end
                ST_PRG_RD: begin
                    if (mem_done) begin
                        rd_dat <= mem_rdat;
                        state  <= ST_PRG_WR;
                    end
                end
                ST_PRG_WR: begin
                    if (mem_done) state <= ST_IDLE;
                end
                ST_ERS: begin
                    if (mem_done) begin
                        if (ers_last) state <= ST_IDLE;
                        else          ers_n <= ers_n_nxt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fla_cmd_seq.sv
// Bench for fla_cmd_seq: behavioural PSRAM with configurable ack latency,
// access log, handshake monitor, and per-feature scenario tasks.
module tb_fla_cmd_seq;

    localparam int ADDR_W = 19;
    localparam int SECT   = 4096;

    logic              clk      = 1'b0;
    logic              map_rst  = 1'b1;
    logic              cpu_we   = 1'b0;
    logic              cpu_re   = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_dat  = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdat;
    logic [7:0]        mem_rdat = '0;
    logic              mem_ack  = 1'b0;
    logic              rd_ovr;
    logic [7:0]        rd_ovr_dat;
    logic              busy;
    logic              map_led;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int ack_dly  = 0;
    int hs_err   = 0;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] log_addr[$];
    logic              log_we[$];
    logic [7:0]        log_dat[$];

    fla_cmd_seq dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_addr   (cpu_addr),
        .cpu_dat    (cpu_dat),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdat   (mem_wdat),
        .mem_rdat   (mem_rdat),
        .mem_ack    (mem_ack),
        .rd_ovr     (rd_ovr),
        .rd_ovr_dat (rd_ovr_dat),
        .busy       (busy),
        .map_led    (map_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks after ack_dly idle cycles, logs accesses, watches the handshake.
    initial begin : responder
        int                wait_cnt;
        logic              req_prev, ack_q;
        logic              we_prev;
        logic [ADDR_W-1:0] addr_prev;
        logic [7:0]        wdat_prev;
        wait_cnt = 0; req_prev = 1'b0; we_prev = 1'b0; addr_prev = '0; wdat_prev = '0;
        forever begin
            @(negedge clk);
            if (map_rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                req_prev = 1'b0;
            end else begin
                ack_q = mem_ack;
                if (ack_q && mem_req) hs_err++;
                if (mem_req && req_prev && !ack_q &&
                    (mem_addr !== addr_prev || mem_we !== we_prev || mem_wdat !== wdat_prev)) hs_err++;
                req_prev = mem_req; addr_prev = mem_addr; we_prev = mem_we; wdat_prev = mem_wdat;
                mem_ack = 1'b0;
                if (mem_req && !ack_q) begin
                    if (wait_cnt < ack_dly) begin
                        wait_cnt++;
                    end else begin
                        wait_cnt = 0;
                        log_addr.push_back(mem_addr);
                        log_we.push_back(mem_we);
                        log_dat.push_back(mem_wdat);
                        if (mem_we) mem[mem_addr] = mem_wdat;
                        else        mem_rdat = mem[mem_addr];
                        mem_ack = 1'b1;
                        ack_cyc = cyc;
                    end
                end
            end
        end
    end

    function automatic logic [ADDR_W-1:0] u1_addr();
        return {4'($urandom_range(0, 15)), 15'h5555};
    endfunction

    function automatic logic [ADDR_W-1:0] u2_addr();
        return {4'($urandom_range(0, 15)), 15'h2AAA};
    endfunction

    task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dat = d; cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic cpu_rd(input logic [ADDR_W-1:0] a, output logic o, output logic [7:0] v);
        cpu_addr = a; cpu_re = 1'b1;
        #1;
        o = rd_ovr; v = rd_ovr_dat;
        @(negedge clk);
        cpu_re = 1'b0;
    endtask

    task automatic unlock();
        cpu_wr(u1_addr(), 8'hAA);
        cpu_wr(u2_addr(), 8'h55);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        unlock();
        cpu_wr(u1_addr(), c);
    endtask

    task automatic clear_log();
        log_addr.delete(); log_we.delete(); log_dat.delete();
    endtask

    task automatic wait_not_busy(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (!busy) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        map_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdat} !== '0) begin
            n_fail++; $display("FAIL reset_mem got req=%0b we=%0b addr=%h wdat=%h want all 0", mem_req, mem_we, mem_addr, mem_wdat);
        end
        n_checks++;
        if ({rd_ovr, rd_ovr_dat} !== 9'h0) begin
            n_fail++; $display("FAIL reset_rd_ovr got %0b/%h want 0/00", rd_ovr, rd_ovr_dat);
        end
        n_checks++;
        if ({busy, map_led} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_led got busy=%0b led=%0b want 0/0", busy, map_led);
        end
        map_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_program();
        logic [ADDR_W-1:0] a;
        logic [7:0]        d, old, exp;
        bit                to;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                a = 19'h01234; d = 8'h5A; mem[a] = 8'hF3; ack_dly = 0;
            end else begin
                a = ADDR_W'($urandom); d = 8'($urandom); ack_dly = $urandom_range(0, 4);
            end
            old = mem[a];
            exp = old & d;
            clear_log();
            send_cmd(8'hA0);
            cpu_wr(a, d);
            #1;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL prg_busy_start it=%0d got %0b want 1", it, busy); end
            wait_not_busy(300, to);
            n_checks++;
            if (to !== 1'b0) begin n_fail++; $display("FAIL prg_timeout it=%0d got timeout want completion", it); end
            n_checks++;
            if (cyc !== ack_cyc + 1) begin n_fail++; $display("FAIL prg_busy_drop it=%0d got cyc %0d want %0d", it, cyc, ack_cyc + 1); end
            n_checks++;
            if (log_addr.size() !== 2) begin
                n_fail++; $display("FAIL prg_access_count it=%0d got %0d want 2", it, log_addr.size());
            end else begin
                n_checks++;
                if ({log_addr[0], log_we[0]} !== {a, 1'b0}) begin
                    n_fail++; $display("FAIL prg_read it=%0d got %h/%0b want %h/0", it, log_addr[0], log_we[0], a);
                end
                n_checks++;
                if ({log_addr[1], log_we[1], log_dat[1]} !== {a, 1'b1, exp}) begin
                    n_fail++; $display("FAIL prg_write it=%0d got %h/%0b/%h want %h/1/%h", it, log_addr[1], log_we[1], log_dat[1], a, exp);
                end
            end
            n_checks++;
            if (mem[a] !== exp) begin n_fail++; $display("FAIL prg_mem it=%0d got %h want %h", it, mem[a], exp); end
            n_checks++;
            if (hs_err !== 0) begin n_fail++; $display("FAIL prg_handshake it=%0d got %0d violations want 0", it, hs_err); end
            @(negedge clk);
        end
    endtask

    task automatic test_polling();
        logic [ADDR_W-1:0] a;
        logic [7:0]        d, v, exp;
        logic              o, tog_m;
        bit                to;
        for (int it = 0; it < 2; it++) begin
            ack_dly = 20;
            a = ADDR_W'($urandom);
            d = (it == 0) ? 8'h5A : 8'($urandom);
            tog_m = 1'b0;
            clear_log();
            send_cmd(8'hA0);
            cpu_wr(a, d);
            repeat (2) @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                if (r == 1) begin
                    cpu_addr = u1_addr(); cpu_dat = 8'hAA; cpu_we = 1'b1; cpu_re = 1'b1;
                    @(negedge clk);
                    cpu_we = 1'b0; cpu_re = 1'b0;
                end
                cpu_rd(ADDR_W'($urandom), o, v);
                exp = {~d[7], tog_m, 6'b0};
                tog_m = ~tog_m;
                n_checks++;
                if ({o, v} !== {1'b1, exp}) begin
                    n_fail++; $display("FAIL poll_status it=%0d rd=%0d got %0b/%h want 1/%h", it, r, o, v, exp);
                end
            end
            wait_not_busy(300, to);
            n_checks++;
            if (to !== 1'b0) begin n_fail++; $display("FAIL poll_timeout it=%0d got timeout want completion", it); end
            cpu_rd(a, o, v);
            n_checks++;
            if (o !== 1'b0) begin n_fail++; $display("FAIL poll_after_ovr it=%0d got %0b want 0", it, o); end
            n_checks++;
            if ({log_addr.size() == 2, map_led} !== 2'b10) begin
                n_fail++; $display("FAIL poll_no_rearm it=%0d got accesses=%0d led=%0b want 2/0", it, log_addr.size(), map_led);
            end
        end
        ack_dly = 0;
    endtask

    task automatic test_bad_seq();
        logic       o;
        logic [7:0] v;
        ack_dly = 0;
        clear_log();
        cpu_wr(u1_addr(), 8'hAA);
        cpu_wr({4'($urandom_range(0, 15)), 15'h2AAB}, 8'h55);
        #1;
        n_checks++;
        if (map_led !== 1'b0) begin n_fail++; $display("FAIL bad_unlock_state got led=%0b want 0", map_led); end
        cpu_wr(u1_addr(), 8'hA0);
        cpu_wr(19'h00100, 8'h77);
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if ({log_addr.size() == 0, busy, map_led} !== 3'b100) begin
            n_fail++; $display("FAIL bad_no_arm got accesses=%0d busy=%0b led=%0b want 0/0/0", log_addr.size(), busy, map_led);
        end
        send_cmd(8'hF0);
        #1;
        n_checks++;
        if (map_led !== 1'b0) begin n_fail++; $display("FAIL bad_f0_reset got led=%0b want 0", map_led); end
        send_cmd(8'h80);
        cpu_wr(u1_addr(), 8'h12);
        #1;
        n_checks++;
        if (map_led !== 1'b0) begin n_fail++; $display("FAIL bad_e80_abort got led=%0b want 0", map_led); end
        cpu_rd(ADDR_W'($urandom), o, v);
        n_checks++;
        if (o !== 1'b0) begin n_fail++; $display("FAIL bad_idle_ovr got %0b want 0", o); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() !== 0) begin n_fail++; $display("FAIL bad_no_mem got %0d accesses want 0", log_addr.size()); end
    endtask

    task automatic test_id_mode();
        logic [ADDR_W-1:0] a;
        logic [7:0]        v, exp;
        logic              o;
        clear_log();
        send_cmd(8'h90);
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      a = '0;
            else if (i == 1) a = 19'h1;
            else             a = ADDR_W'($urandom);
            exp = a[0] ? 8'hB7 : 8'hBF;
            if (i == 3) cpu_wr(ADDR_W'($urandom), 8'h12);
            cpu_rd(a, o, v);
            n_checks++;
            if ({o, v} !== {1'b1, exp}) begin
                n_fail++; $display("FAIL id_read i=%0d addr=%h got %0b/%h want 1/%h", i, a, o, v, exp);
            end
        end
        cpu_wr(ADDR_W'($urandom), 8'hF0);
        cpu_rd(ADDR_W'($urandom), o, v);
        n_checks++;
        if ({o, map_led} !== 2'b00) begin n_fail++; $display("FAIL id_exit got ovr=%0b led=%0b want 0/0", o, map_led); end
        n_checks++;
        if (log_addr.size() !== 0) begin n_fail++; $display("FAIL id_no_mem got %0d accesses want 0", log_addr.size()); end
    endtask

    task automatic test_sector_erase();
        logic [ADDR_W-1:0] base;
        logic [7:0]        v, below, above;
        logic              o;
        bit                to;
        int                errs;
        base  = 19'h23000;
        below = mem[base - 1];
        above = mem[base + SECT];
        ack_dly = 0;
        clear_log();
        send_cmd(8'h80);
        unlock();
        cpu_wr(19'h23456, 8'h30);
        for (int r = 0; r < 2; r++) begin
            cpu_rd(ADDR_W'($urandom), o, v);
            n_checks++;
            if ({o, v} !== {1'b1, (r == 0) ? 8'h00 : 8'h40}) begin
                n_fail++; $display("FAIL ers_status rd=%0d got %0b/%h want 1/%h", r, o, v, (r == 0) ? 8'h00 : 8'h40);
            end
        end
        wait_not_busy(20000, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL ers_timeout got timeout want completion"); end
        n_checks++;
        if (cyc !== ack_cyc + 1) begin n_fail++; $display("FAIL ers_busy_drop got cyc %0d want %0d", cyc, ack_cyc + 1); end
        n_checks++;
        if (log_addr.size() !== SECT) begin n_fail++; $display("FAIL ers_count got %0d want %0d", log_addr.size(), SECT); end
        errs = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if ({log_addr[i], log_we[i], log_dat[i]} !== {base + ADDR_W'(i), 1'b1, 8'hFF}) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL ers_order got %0d bad writes want 0", errs); end
        errs = 0;
        for (int i = 0; i < SECT; i++)
            if (mem[base + ADDR_W'(i)] !== 8'hFF) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL ers_fill got %0d non-FF bytes want 0", errs); end
        n_checks++;
        if ({mem[base - 1], mem[base + SECT]} !== {below, above}) begin
            n_fail++; $display("FAIL ers_bounds got %h/%h want %h/%h", mem[base - 1], mem[base + SECT], below, above);
        end
        n_checks++;
        if (hs_err !== 0) begin n_fail++; $display("FAIL ers_handshake got %0d violations want 0", hs_err); end
    endtask

    task automatic test_reset_mid_erase();
        logic [ADDR_W-1:0] base, a;
        logic [7:0]        d, old;
        bit                to;
        int                n, errs;
        base    = ADDR_W'($urandom) & ~ADDR_W'(SECT - 1);
        ack_dly = $urandom_range(0, 2);
        clear_log();
        send_cmd(8'h80);
        unlock();
        cpu_wr(base | ADDR_W'($urandom_range(0, SECT - 1)), 8'h30);
        for (int i = 0; i < 2000 && log_addr.size() < 100; i++) @(negedge clk);
        n_checks++;
        if (log_addr.size() < 100) begin n_fail++; $display("FAIL rst_reach100 got %0d writes want >=100", log_addr.size()); end
        errs = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] !== base + ADDR_W'(i)) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL rst_ers_order got %0d bad addresses want 0", errs); end
        map_rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({mem_req, busy, map_led, rd_ovr} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_abort got req=%0b busy=%0b led=%0b ovr=%0b want 0/0/0/0", mem_req, busy, map_led, rd_ovr);
        end
        map_rst = 1'b0;
        n = log_addr.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if (log_addr.size() !== n) begin n_fail++; $display("FAIL rst_no_resume got %0d accesses want %0d", log_addr.size(), n); end
        a = ADDR_W'($urandom); d = 8'($urandom); old = mem[a];
        clear_log();
        send_cmd(8'hA0);
        cpu_wr(a, d);
        wait_not_busy(300, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rst_prg_timeout got timeout want completion"); end
        n_checks++;
        if ({log_addr.size() == 2, mem[a]} !== {1'b1, old & d}) begin
            n_fail++; $display("FAIL rst_prg_after got accesses=%0d mem=%h want 2/%h", log_addr.size(), mem[a], old & d);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        test_reset();
        test_program();
        test_polling();
        test_bad_seq();
        test_id_mode();
        test_sector_erase();
        test_reset_mid_erase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog got no completion within 60000 cycles want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
